// File: rtl/gcd_result_display.sv
// Result display stage for the GCD processor. It captures Result on a rising Halt
// and converts it to BCD by shift-add-3. It then scans three active-low 7-segment digits.
module gcd_result_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Halt,
  input  logic [7:0]  Result,
  output logic        Busy,
  output logic        Valid,
  output logic [11:0] Bcd,
  output logic [6:0]  Segments,
  output logic [2:0]  DigitSel
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;
  typedef enum logic [1:0] {DIG_ONES, DIG_TENS, DIG_HUNDREDS} digit_t;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  state_t            state;
  digit_t            digit_idx;
  digit_t            digit_next;
  logic              halt_d;
  logic [7:0]        shift_reg;
  logic [11:0]       acc;
  logic [11:0]       acc_adj;
  logic [11:0]       acc_next;
  logic [2:0]        iter;
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_wrap;
  logic              capture;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] add3(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int i = 0; i < 3; i++)
      if (a[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  // Returns {DigitSel, Segments}; leading zeros blank but keep their select asserted.
  function automatic logic [9:0] show_digit(input logic [11:0] bcd, input digit_t idx);
    logic [6:0] seg;
    logic [2:0] sel;
    case (idx)
      DIG_HUNDREDS: begin
        sel = 3'b011;
        seg = (bcd[11:8] == 4'd0) ? 7'h7F : seg_code(bcd[11:8]);
      end
      DIG_TENS: begin
        sel = 3'b101;
        seg = (bcd[11:4] == 8'd0) ? 7'h7F : seg_code(bcd[7:4]);
      end
      default: begin
        sel = 3'b110;
        seg = seg_code(bcd[3:0]);
      end
    endcase
    return {sel, seg};
  endfunction

  assign capture   = Halt & ~halt_d;
  assign acc_adj   = add3(acc);
  assign acc_next  = {acc_adj[10:0], shift_reg[7]};
  assign scan_wrap = (scan_cnt == SCAN_LAST);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    digit_next = digit_idx;
    if (scan_wrap) begin
      case (digit_idx)
        DIG_ONES: digit_next = DIG_TENS;
        DIG_TENS: digit_next = DIG_HUNDREDS;
        default:  digit_next = DIG_ONES;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    // Tracks Halt even in reset, so a Halt held through reset cannot capture.
    halt_d <= Halt;
    if (Reset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Valid     <= 1'b0;
      Bcd       <= 12'h000;
      Segments  <= 7'h7F;
      DigitSel  <= 3'b111;
      scan_cnt  <= '0;
      digit_idx <= DIG_ONES;
      shift_reg <= 8'h00;
      acc       <= 12'h000;
      iter      <= 3'd0;
    end else if (capture && state != CONVERT) begin
      state     <= CONVERT;
      shift_reg <= Result;
      acc       <= 12'h000;
      iter      <= 3'd0;
      Busy      <= 1'b1;
      Valid     <= 1'b0;
      Segments  <= 7'h7F;
      DigitSel  <= 3'b111;
    end else begin
      case (state)
        CONVERT: begin
          acc       <= acc_next;
          shift_reg <= {shift_reg[6:0], 1'b0};
          iter      <= iter + 3'd1;
          if (iter == 3'd7) begin
            state                <= SHOW;
            Bcd                  <= acc_next;
            Busy                 <= 1'b0;
            Valid                <= 1'b1;
            scan_cnt             <= '0;
            digit_idx            <= DIG_ONES;
            {DigitSel, Segments} <= show_digit(acc_next, DIG_ONES);
          end
        end
        SHOW: begin
          scan_cnt             <= scan_wrap ? '0 : scan_cnt + 1'b1;
          digit_idx            <= digit_next;
          {DigitSel, Segments} <= show_digit(Bcd, digit_next);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_result_display.sv
// Directed bench for gcd_result_display: conversions, scan order, blanking,
// Halt edge handling and reset in the middle of a conversion.
module tb_gcd_result_display;

  localparam int SCAN = 4;

  logic        Clock;
  logic        Reset;
  logic        Halt;
  logic [7:0]  Result;
  logic        Busy;
  logic        Valid;
  logic [11:0] Bcd;
  logic [6:0]  Segments;
  logic [2:0]  DigitSel;

  int checks = 0;
  int fails  = 0;

  gcd_result_display #(.SCAN_DIV(SCAN)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Halt     (Halt),
    .Result   (Result),
    .Busy     (Busy),
    .Valid    (Valid),
    .Bcd      (Bcd),
    .Segments (Segments),
    .DigitSel (DigitSel)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'(Busy),     32'h0);
    check({tag, "_valid"}, 32'(Valid),    32'h0);
    check({tag, "_bcd"},   32'(Bcd),      32'h000);
    check({tag, "_seg"},   32'(Segments), 32'h7F);
    check({tag, "_sel"},   32'(DigitSel), 32'h7);
  endtask

  // Capture edge N, then seven busy cycles, then the result at edge N+8.
  task automatic convert(input logic [7:0] val, input logic [11:0] exp_bcd,
                         input logic [11:0] prev_bcd);
    Result = val;
    Halt   = 1'b1;
    tick();
    check("cap_busy",  32'(Busy),     32'h1);
    check("cap_valid", 32'(Valid),    32'h0);
    check("cap_sel",   32'(DigitSel), 32'h7);
    check("cap_seg",   32'(Segments), 32'h7F);
    check("cap_bcd",   32'(Bcd),      32'(prev_bcd));
    Halt = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("conv_busy", 32'(Busy), 32'h1);
    end
    check("conv_bcd_held", 32'(Bcd), 32'(prev_bcd));
    tick();
    check("done_busy",  32'(Busy),  32'h0);
    check("done_valid", 32'(Valid), 32'h1);
    check("done_bcd",   32'(Bcd),   32'(exp_bcd));
  endtask

  // Two full rotations starting at the edge that entered SHOW.
  task automatic scan(input logic [6:0] seg_h, input logic [6:0] seg_t, input logic [6:0] seg_o);
    logic [2:0] exp_sel;
    logic [6:0] exp_seg;
    for (int k = 0; k < 6 * SCAN; k++) begin
      case ((k / SCAN) % 3)
        0:       begin exp_sel = 3'b110; exp_seg = seg_o; end
        1:       begin exp_sel = 3'b101; exp_seg = seg_t; end
        default: begin exp_sel = 3'b011; exp_seg = seg_h; end
      endcase
      check("scan_sel", 32'(DigitSel), 32'(exp_sel));
      check("scan_seg", 32'(Segments), 32'(exp_seg));
      tick();
    end
  endtask

  initial begin
    int busy_cycles;
    Reset  = 1'b1;
    Halt   = 1'b0;
    Result = 8'd0;
    tick();
    tick();
    check_reset_values("reset");
    Reset = 1'b0;
    tick();
    check("idle_busy", 32'(Busy), 32'h0);

    convert(8'd255, 12'h255, 12'h000);
    scan(7'h24, 7'h12, 7'h12);
    convert(8'd7, 12'h007, 12'h255);
    scan(7'h7F, 7'h7F, 7'h78);
    convert(8'd100, 12'h100, 12'h007);
    scan(7'h79, 7'h40, 7'h40);
    convert(8'd0, 12'h000, 12'h100);
    scan(7'h7F, 7'h7F, 7'h40);

    // Halt held high for 30 cycles gives exactly one conversion.
    Result      = 8'd9;
    Halt        = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 10) Result = 8'd50;
      if (Busy) busy_cycles++;
    end
    check("hold_busy_cycles", 32'(busy_cycles), 32'd8);
    check("hold_bcd",   32'(Bcd),   32'h009);
    check("hold_valid", 32'(Valid), 32'h1);
    Halt = 1'b0;
    tick();

    // A second Halt edge during CONVERT is ignored and not queued.
    Result = 8'd33;
    Halt   = 1'b1;
    tick();
    Halt = 1'b0;
    tick();
    Result = 8'd77;
    Halt   = 1'b1;
    tick();
    Halt = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("glitch_busy_n7", 32'(Busy), 32'h1);
    tick();
    check("glitch_bcd",   32'(Bcd),   32'h033);
    check("glitch_valid", 32'(Valid), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    check("glitch_no_requeue", 32'(Busy), 32'h0);
    check("glitch_bcd_kept",   32'(Bcd),  32'h033);

    // Reset after four iterations of 200, with Halt held high through reset.
    Result = 8'd200;
    Halt   = 1'b1;
    tick();
    Halt = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy", 32'(Busy), 32'h1);
    Reset = 1'b1;
    Halt  = 1'b1;
    tick();
    check_reset_values("abort");
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("post_reset_busy",  32'(Busy),  32'h0);
    check("post_reset_valid", 32'(Valid), 32'h0);
    check("post_reset_bcd",   32'(Bcd),   32'h000);
    Halt = 1'b0;
    tick();
    convert(8'd42, 12'h042, 12'h000);
    scan(7'h7F, 7'h19, 7'h24);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
